// File: rtl/riscv_dmem_resp.sv
// Data-memory responder: byte-lane aligned loads/stores into an on-chip word array after LATENCY wait states.
// Optional feature macro RISCV_DMEM_MISALIGN_TRAP_EN: flag misaligned accesses instead of force-aligning them.
module riscv_dmem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 1
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_wr_en,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_byte_sel,
  input  logic [2:0]  i_req_funct3,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);
  localparam int         AW       = DEPTH_LOG2 + 2;
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;

  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    bsel_q;
  logic [2:0]    f3_q;
  logic          wr_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   mem_q [DEPTH];

  logic          accept, access;
  logic [AW-1:0] a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_bsel;
  logic [2:0]    a_f3;
  logic          a_wr;
  logic          is_byte, is_half, is_word, mis;
  logic [1:0]    off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [3:0]    lane;
  logic [31:0]   wsh, rword, ext;

  logic unused_addr;
  assign unused_addr = ^i_req_addr[31:AW];

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign accept      = i_req_valid && o_req_ready;

  // With zero latency the access happens on the acceptance edge, straight from the request ports.
  always_comb begin
    if (LATENCY == 0) begin
      a_addr  = i_req_addr[AW-1:0];
      a_wdata = i_req_wdata;
      a_bsel  = i_req_byte_sel;
      a_f3    = i_req_funct3;
      a_wr    = i_req_wr_en;
    end else begin
      a_addr  = addr_q;
      a_wdata = wdata_q;
      a_bsel  = bsel_q;
      a_f3    = f3_q;
      a_wr    = wr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 0) begin
          access  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == 4'd0) begin
        access  = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      RESP: if (i_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Undefined funct3 encodings fall into the word case.
  always_comb begin
    is_byte = (a_f3[1:0] == 2'b00);
    is_half = (a_f3[1:0] == 2'b01);
    is_word = !is_byte && !is_half;
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    mis = (is_half && a_addr[0]) || (is_word && (a_addr[1:0] != 2'b00));
    off = a_addr[1:0];
`else
    mis = 1'b0;
    off = is_word ? 2'b00 : is_half ? {a_addr[1], 1'b0} : a_addr[1:0];
`endif
    idx   = a_addr[AW-1:2];
    lane  = a_bsel << off;
    wsh   = a_wdata << {off, 3'b000};
    rword = mem_q[idx] >> {off, 3'b000};
    case (a_f3)
      3'b000:  ext = {{24{rword[7]}}, rword[7:0]};
      3'b001:  ext = {{16{rword[15]}}, rword[15:0]};
      3'b100:  ext = {24'd0, rword[7:0]};
      3'b101:  ext = {16'd0, rword[15:0]};
      default: ext = rword;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      bsel_q  <= 4'd0;
      f3_q    <= 3'd0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= i_req_addr[AW-1:0];
        wdata_q <= i_req_wdata;
        bsel_q  <= i_req_byte_sel;
        f3_q    <= i_req_funct3;
        wr_q    <= i_req_wr_en;
      end
      if (access) begin
        rdata_q <= (a_wr || mis) ? 32'd0 : ext;
        err_q   <= mis;
      end
    end
  end

  // Array is never reset; the write is gated so a request seen during reset cannot commit.
  always_ff @(posedge i_clk) begin
    if (i_rstn && access && a_wr && !mis) begin
      for (int b = 0; b < 4; b++)
        if (lane[b]) mem_q[idx][8*b +: 8] <= wsh[8*b +: 8];
    end
  end
endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Randomized self-checking bench: two responders (LATENCY 1 and 4) against a byte-addressed memory model.
module tb_riscv_dmem_resp;
  logic        clk;
  logic        rstn      [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_wr    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_bsel  [2];
  logic [2:0]  req_f3    [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int errors = 0;
  int checks = 0;
  logic [7:0] mdl [int];

  riscv_dmem_resp #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut0 (
    .i_clk(clk), .i_rstn(rstn[0]), .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_wr_en(req_wr[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .i_req_byte_sel(req_bsel[0]), .i_req_funct3(req_f3[0]), .o_rsp_valid(rsp_valid[0]),
    .i_rsp_ready(rsp_ready[0]), .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0]));

  riscv_dmem_resp #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut1 (
    .i_clk(clk), .i_rstn(rstn[1]), .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_wr_en(req_wr[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .i_req_byte_sel(req_bsel[1]), .i_req_funct3(req_f3[1]), .o_rsp_valid(rsp_valid[1]),
    .i_rsp_ready(rsp_ready[1]), .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte-level reference: bytes per access from funct3, misalignment handled by macro.
  task automatic model(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int nb, off, base;
    logic [31:0] v;
    bit mis;
    nb   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(addr[1:0]);
    base = d * 65536 + int'(addr & 32'h0000_0FFC);
    mis  = (nb == 2 && (off % 2) == 1) || (nb == 4 && off != 0);
    rd = 32'd0;
    er = 1'b0;
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    if (mis) begin er = 1'b1; return; end
`else
    if (mis) off = (nb == 2) ? off - 1 : 0;
`endif
    if (wr) begin
      for (int i = 0; i < nb; i++) mdl[base + off + i] = wdata[8*i +: 8];
    end else begin
      v = 32'd0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = mdl[base + off + i];
      if (nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      rd = v;
    end
  endtask

  task automatic issue(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] f3, output int lat);
    int k;
    @(negedge clk);
    req_wr[d] = wr; req_addr[d] = addr; req_wdata[d] = wdata; req_f3[d] = f3;
    req_bsel[d] = (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    rsp_ready[d] = 1'b0;
    req_valid[d] = 1'b1;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (rsp_valid[d] !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
  endtask

  task automatic consume(input int d);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
  endtask

  task automatic op(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [2:0] f3, output logic [31:0] got, output logic gerr, output int lat,
                    output logic [31:0] exp, output logic eerr);
    model(d, wr, addr, wdata, f3, exp, eerr);
    issue(d, wr, addr, wdata, f3, lat);
    got  = rsp_rdata[d];
    gerr = rsp_err[d];
    consume(d);
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rstn[d] = 1'b0; req_valid[d] = 1'b0; rsp_ready[d] = 1'b0; req_wr[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; req_bsel[d] = 4'd0; req_f3[d] = 3'd0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (req_ready[d] !== 1'b1) begin errors++; $display("FAIL reset_ready[%0d]: got %b want 1", d, req_ready[d]); end
      checks++; if (rsp_valid[d] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", d, rsp_valid[d]); end
      checks++; if (rsp_rdata[d] !== 32'd0) begin errors++; $display("FAIL reset_rdata[%0d]: got %h want 0", d, rsp_rdata[d]); end
      checks++; if (rsp_err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b want 0", d, rsp_err[d]); end
    end
    rstn[0] = 1'b1;
    rstn[1] = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] got, exp; logic gerr, eerr; int lat;
    op(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d want 2", lat); end
    checks++; if (got !== 32'd0) begin errors++; $display("FAIL sw_rdata: got %h want 0", got); end
    op(0, 1'b0, 32'h10, 32'h0, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d want 2", lat); end
    checks++; if (got !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_word: got %h want deadbeef", got); end
    op(0, 1'b1, 32'h13, 32'h0000005A, 3'b000, got, gerr, lat, exp, eerr);
    op(0, 1'b0, 32'h10, 32'h0, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (got !== 32'h5AADBEEF) begin errors++; $display("FAIL sb_merge: got %h want 5aadbeef", got); end
  endtask

  task automatic test_extend();
    logic [31:0] got, exp; logic gerr, eerr; int lat;
    logic [2:0]  f3s  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011, 3'b000};
    logic [31:0] ads  [6] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h20, 32'h21};
    logic [31:0] want [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8080, 32'h00008080, 32'h00008080, 32'hFFFFFF80};
    op(0, 1'b1, 32'h20, 32'h00008080, 3'b010, got, gerr, lat, exp, eerr);
    for (int i = 0; i < 6; i++) begin
      op(0, 1'b0, ads[i], 32'h0, f3s[i], got, gerr, lat, exp, eerr);
      checks++; if (got !== want[i]) begin errors++; $display("FAIL extend[%0d] f3=%b: got %h want %h", i, f3s[i], got, want[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp; logic eerr; int lat;
    model(0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, exp, eerr);
    issue(0, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010, lat);
    for (int c = 0; c < 3; c++) begin
      checks++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
        errors++; $display("FAIL hold[%0d]: got valid=%b rdata=%h err=%b ready=%b want 1/0/0/0", c, rsp_valid[0], rsp_rdata[0], rsp_err[0], req_ready[0]);
      end
      @(negedge clk);
    end
    consume(0);
    checks++; if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
      errors++; $display("FAIL hold_release: got ready=%b valid=%b want 1/0", req_ready[0], rsp_valid[0]);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] got, exp; logic gerr, eerr; int lat;
    logic exp_err; logic [31:0] exp_word;
`ifdef RISCV_DMEM_MISALIGN_TRAP_EN
    exp_err = 1'b1; exp_word = 32'hFFFFFFFF;
`else
    exp_err = 1'b0; exp_word = 32'hFFFF1234;
`endif
    op(0, 1'b1, 32'h40, 32'hFFFFFFFF, 3'b010, got, gerr, lat, exp, eerr);
    op(0, 1'b1, 32'h41, 32'h00001234, 3'b001, got, gerr, lat, exp, eerr);
    checks++; if (gerr !== exp_err) begin errors++; $display("FAIL mis_err: got %b want %b", gerr, exp_err); end
    op(0, 1'b0, 32'h40, 32'h0, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (got !== exp_word) begin errors++; $display("FAIL mis_word: got %h want %h", got, exp_word); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp; logic eerr; int last, rises; logic prev;
    model(0, 1'b0, 32'h10, 32'h0, 3'b010, exp, eerr);
    @(negedge clk);
    req_wr[0] = 1'b0; req_addr[0] = 32'h10; req_f3[0] = 3'b010; req_bsel[0] = 4'b1111;
    req_valid[0] = 1'b1; rsp_ready[0] = 1'b1;
    prev = 1'b0; last = 0; rises = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid[0] === 1'b1 && prev !== 1'b1) begin
        if (rises > 0) begin
          checks++; if (c - last !== 3) begin errors++; $display("FAIL b2b_period: got %0d want 3", c - last); end
        end
        checks++; if (rsp_rdata[0] !== exp) begin errors++; $display("FAIL b2b_rdata: got %h want %h", rsp_rdata[0], exp); end
        last = c;
        rises++;
      end
      prev = rsp_valid[0];
    end
    req_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    rsp_ready[0] = 1'b0;
    checks++; if (rises < 6) begin errors++; $display("FAIL b2b_count: got %0d want >=6", rises); end
  endtask

  task automatic test_random();
    logic [31:0] got, exp; logic gerr, eerr; int lat;
    logic [2:0] lf [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] f3; logic wr; logic [31:0] addr;
    for (int w = 0; w < 16; w++)
      op(0, 1'b1, 32'h100 + 32'(4*w), $urandom, 3'b010, got, gerr, lat, exp, eerr);
    for (int n = 0; n < 40; n++) begin
      wr   = 1'($urandom_range(0, 1));
      f3   = wr ? lf[$urandom_range(0, 2)] : lf[$urandom_range(0, 4)];
      addr = 32'h100 + 32'($urandom_range(0, 63));
      op(0, wr, addr, $urandom, f3, got, gerr, lat, exp, eerr);
      checks++; if (got !== exp || gerr !== eerr || lat !== 2) begin
        errors++; $display("FAIL rand[%0d] wr=%b f3=%b a=%h: got %h/%b/%0d want %h/%b/2", n, wr, f3, addr, got, gerr, lat, exp, eerr);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp; logic gerr, eerr; int lat;
    op(1, 1'b1, 32'h50, 32'h22222222, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (lat !== 5) begin errors++; $display("FAIL lat4_latency: got %0d want 5", lat); end
    op(1, 1'b0, 32'h50, 32'h0, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (got !== 32'h22222222) begin errors++; $display("FAIL lat4_lw: got %h want 22222222", got); end
    @(negedge clk);
    req_wr[1] = 1'b1; req_addr[1] = 32'h50; req_wdata[1] = 32'h11111111; req_f3[1] = 3'b010;
    req_bsel[1] = 4'b1111; req_valid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL wait_ready: got %b want 0", req_ready[1]); end
    @(posedge clk);
    #2 rstn[1] = 1'b0;
    #1;
    checks++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0 || rsp_err[1] !== 1'b0) begin
      errors++; $display("FAIL wait_reset: got ready=%b valid=%b rdata=%h err=%b want 1/0/0/0", req_ready[1], rsp_valid[1], rsp_rdata[1], rsp_err[1]);
    end
    @(negedge clk);
    rstn[1] = 1'b1;
    op(1, 1'b0, 32'h50, 32'h0, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (got !== 32'h22222222) begin errors++; $display("FAIL abort_kept: got %h want 22222222", got); end
    model(1, 1'b1, 32'h54, 32'h33333333, 3'b010, exp, eerr);
    issue(1, 1'b1, 32'h54, 32'h33333333, 3'b010, lat);
    rstn[1] = 1'b0;
    #1;
    checks++; if (rsp_valid[1] !== 1'b0) begin errors++; $display("FAIL resp_reset: got %b want 0", rsp_valid[1]); end
    @(negedge clk);
    rstn[1] = 1'b1;
    op(1, 1'b0, 32'h54, 32'h0, 3'b010, got, gerr, lat, exp, eerr);
    checks++; if (got !== 32'h33333333) begin errors++; $display("FAIL resp_committed: got %h want 33333333", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extend();
    test_backpressure();
    test_misalign();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
